matmul_job_sched: RTL and testbench
===================================

# matmul_job_sched

Job scheduler in front of the matrix-multiply datapath. Software stages a job, consisting of an A buffer index, a B buffer index and an output buffer index, through MMIO registers. A doorbell write pushes the job into a small FIFO. The scheduler pops jobs one at a time, pulses `mul_start` with the job's buffer selects held stable, waits for `mul_done`, and counts completions. It sits between the host MMIO port and the multiplier control inputs, so several multiplies can be queued without host polling between them.

## Interface
Parameters:
- MMIO_WIDTH, 32, MMIO data width
- MMIO_ADDRBITS, 32, MMIO address width
- QDEPTH, 4, job FIFO depth; power of two, 2 or greater
- SEL_BITS, 4, width of each buffer-select field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mmio_w_req  in  1  MMIO write strobe
- mmio_w_addr  in  MMIO_ADDRBITS  write register address
- mmio_w_data  in  MMIO_WIDTH  write data
- mmio_r_req  in  1  MMIO read strobe
- mmio_r_addr  in  MMIO_ADDRBITS  read register address
- mmio_r_data  out  MMIO_WIDTH  registered read data; holds its value between reads
- mul_start  out  1  one-cycle start pulse to the datapath
- mul_a_sel, mul_b_sel, mul_out_sel  out  SEL_BITS each  buffer selects of the active job
- mul_done  in  1  one-cycle completion pulse from the datapath

## Operation
Register map (writes take effect on the clock edge where `mmio_w_req` is high):
- 0x00 JOB_A, 0x08 JOB_B, 0x10 JOB_OUT: read/write staging registers; the low SEL_BITS bits are stored, upper bits read as 0.
- 0x18 DOORBELL, write only; data ignored.
  - If the FIFO is not full: push {JOB_A, JOB_B, JOB_OUT}.
  - If the FIFO is full: drop the job and set sticky `overflow`.
- 0x20 STATUS, read: bit0 busy (state ≠ IDLE), bit1 overflow, bits[15:8] FIFO occupancy, other bits 0. Writing bit1 = 1 clears overflow.
- 0x28 DONE_CNT, read: count of completed jobs, MMIO_WIDTH bits, wraps modulo 2^MMIO_WIDTH. Any write clears it to 0.
- Reads of unmapped addresses leave `mmio_r_data` unchanged. Writes to unmapped addresses are ignored.

FSM states:
- IDLE: if the FIFO is non-empty, pop the head into the sel output registers and go to ISSUE.
- ISSUE: `mul_start` = 1 for this cycle only; go to WAIT.
- WAIT: on `mul_done`, increment DONE_CNT and go to IDLE. Otherwise stay in WAIT.

Rules:
- `mul_done` is ignored outside WAIT.
- The sel outputs change only on a pop and are held stable through ISSUE and WAIT.
- Push and pop in the same cycle: both happen and occupancy is unchanged.
- Push when full with a pop in the same cycle: the push is still rejected, because fullness is evaluated on the pre-edge occupancy.
- Overflow set and overflow clear in the same cycle: set wins.
- DONE_CNT clear and increment in the same cycle: the clear wins and the result is 0.
- The FIFO pointers are log2(QDEPTH) bits and wrap. Occupancy is log2(QDEPTH)+1 bits.

## Timing
- Reset, and reset asserted mid-job:
  - Outputs: `mul_start` 0, all sel outputs 0, `mmio_r_data` 0.
  - State returns to IDLE, the FIFO is emptied, and overflow, DONE_CNT and the staging registers are cleared.
  - An in-flight job is abandoned and a `mul_done` arriving later is ignored.
- MMIO read latency: 1 cycle. `mmio_r_data` is valid on the edge after `mmio_r_req`. A STATUS read reflects state before that edge's updates.
- Doorbell at edge t, FIFO empty, state IDLE:
  - Job is in the FIFO after edge t.
  - Popped at edge t+1 (sel outputs valid).
  - `mul_start` is high during the cycle after edge t+1; WAIT after edge t+2.
- `mul_done` sampled in WAIT at edge d: DONE_CNT is updated and the state is IDLE after d. The next queued job is popped at d+1 and starts after d+1.
- Minimum spacing between `mul_start` pulses is 3 cycles.

## Test plan
- Stage A=1, B=2, OUT=3, ring the doorbell, return `mul_done` 5 cycles after `mul_start` -> exactly one `mul_start` pulse, sels 1/2/3, DONE_CNT reads 1, STATUS busy reads 0.
- Queue 4 jobs (sels 0..3) with `mul_done` held low -> occupancy reads 3 after the first pop. Then pulse `mul_done` four times -> 4 starts in FIFO order, DONE_CNT = 4.
- Ring the doorbell 6 times while the datapath is stalled in WAIT -> 4 queued, 2 dropped, STATUS overflow = 1. Write 0x20 with bit1 = 1 -> overflow reads 0.
- Pulse `mul_done` in IDLE and in ISSUE -> DONE_CNT stays 0 and no state change.
- Assert `rst` during WAIT with 2 jobs queued, then pulse `mul_done` -> STATUS 0, DONE_CNT 0, no further `mul_start`.
- Doorbell and pop in the same edge with the FIFO full and the datapath finishing -> occupancy stays QDEPTH-1 after that edge, overflow = 1.

Source files
------------

// File: rtl/matmul_job_sched.sv
// MMIO-staged job FIFO in front of the matrix-multiply datapath: pops one job at a
// time, pulses mul_start with held buffer selects, and counts mul_done completions.
module matmul_job_sched #(
    parameter int unsigned MMIO_WIDTH    = 32,
    parameter int unsigned MMIO_ADDRBITS = 32,
    parameter int unsigned QDEPTH        = 4,
    parameter int unsigned SEL_BITS      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mmio_w_req,
    input  logic [MMIO_ADDRBITS-1:0] mmio_w_addr,
    input  logic [MMIO_WIDTH-1:0]    mmio_w_data,
    input  logic                     mmio_r_req,
    input  logic [MMIO_ADDRBITS-1:0] mmio_r_addr,
    output logic [MMIO_WIDTH-1:0]    mmio_r_data,
    output logic                     mul_start,
    output logic [SEL_BITS-1:0]      mul_a_sel,
    output logic [SEL_BITS-1:0]      mul_b_sel,
    output logic [SEL_BITS-1:0]      mul_out_sel,
    input  logic                     mul_done
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned JOB_W = 3 * SEL_BITS;

    localparam logic [MMIO_ADDRBITS-1:0] ADDR_JOB_A    = MMIO_ADDRBITS'(8'h00);
    localparam logic [MMIO_ADDRBITS-1:0] ADDR_JOB_B    = MMIO_ADDRBITS'(8'h08);
    localparam logic [MMIO_ADDRBITS-1:0] ADDR_JOB_OUT  = MMIO_ADDRBITS'(8'h10);
    localparam logic [MMIO_ADDRBITS-1:0] ADDR_DOORBELL = MMIO_ADDRBITS'(8'h18);
    localparam logic [MMIO_ADDRBITS-1:0] ADDR_STATUS   = MMIO_ADDRBITS'(8'h20);
    localparam logic [MMIO_ADDRBITS-1:0] ADDR_DONE_CNT = MMIO_ADDRBITS'(8'h28);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [SEL_BITS-1:0]     job_a_q, job_a_d, job_b_q, job_b_d, job_o_q, job_o_d;
    logic [SEL_BITS-1:0]     a_sel_q, a_sel_d, b_sel_q, b_sel_d, o_sel_q, o_sel_d;
    logic [JOB_W-1:0]        mem_q [QDEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [MMIO_WIDTH-1:0]   done_cnt_q, done_cnt_d;
    logic [MMIO_WIDTH-1:0]   r_data_q, r_data_d;
    logic                    start_q, start_d;
    logic                    push_c, pop_c, full_c, ovf_set_c, ovf_clr_c, done_clr_c, done_inc_c;
    logic [MMIO_WIDTH-1:0]   status_c;
    logic                    unused_data_c;

    assign unused_data_c = ^mmio_w_data[MMIO_WIDTH-1:SEL_BITS];

    // Register decode, FIFO bookkeeping, FSM and read mux
    always_comb begin
        state_d    = state_q;
        job_a_d    = job_a_q;
        job_b_d    = job_b_q;
        job_o_d    = job_o_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        o_sel_d    = o_sel_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        r_data_d   = r_data_q;
        start_d    = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        ovf_set_c  = 1'b0;
        ovf_clr_c  = 1'b0;
        done_clr_c = 1'b0;
        done_inc_c = 1'b0;
        full_c     = (count_q == CNT_W'(QDEPTH));

        status_c       = '0;
        status_c[0]    = (state_q != S_IDLE);
        status_c[1]    = ovf_q;
        status_c[15:8] = 8'(count_q);

        if (mmio_w_req) begin
            case (mmio_w_addr)
                ADDR_JOB_A:    job_a_d = mmio_w_data[SEL_BITS-1:0];
                ADDR_JOB_B:    job_b_d = mmio_w_data[SEL_BITS-1:0];
                ADDR_JOB_OUT:  job_o_d = mmio_w_data[SEL_BITS-1:0];
                ADDR_DOORBELL: begin
                    if (full_c) ovf_set_c = 1'b1;
                    else        push_c    = 1'b1;
                end
                ADDR_STATUS:   ovf_clr_c  = mmio_w_data[1];
                ADDR_DONE_CNT: done_clr_c = 1'b1;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c                       = 1'b1;
                    {a_sel_d, b_sel_d, o_sel_d} = mem_q[rd_ptr_q];
                    start_d                     = 1'b1;
                    state_d                     = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    done_inc_c = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // Set beats clear; clear beats increment
        ovf_d = ovf_set_c ? 1'b1 : (ovf_clr_c ? 1'b0 : ovf_q);
        done_cnt_d = done_clr_c ? '0 :
                     (done_inc_c ? done_cnt_q + MMIO_WIDTH'(1) : done_cnt_q);

        if (mmio_r_req) begin
            case (mmio_r_addr)
                ADDR_JOB_A:    r_data_d = MMIO_WIDTH'(job_a_q);
                ADDR_JOB_B:    r_data_d = MMIO_WIDTH'(job_b_q);
                ADDR_JOB_OUT:  r_data_d = MMIO_WIDTH'(job_o_q);
                ADDR_STATUS:   r_data_d = status_c;
                ADDR_DONE_CNT: r_data_d = done_cnt_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            job_a_q    <= '0;
            job_b_q    <= '0;
            job_o_q    <= '0;
            a_sel_q    <= '0;
            b_sel_q    <= '0;
            o_sel_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            done_cnt_q <= '0;
            r_data_q   <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_a_q    <= job_a_d;
            job_b_q    <= job_b_d;
            job_o_q    <= job_o_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            o_sel_q    <= o_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            done_cnt_q <= done_cnt_d;
            r_data_q   <= r_data_d;
            start_q    <= start_d;
        end
    end

    // Job storage needs no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (!rst && push_c) mem_q[wr_ptr_q] <= {job_a_q, job_b_q, job_o_q};
    end

    assign mmio_r_data = r_data_q;
    assign mul_start   = start_q;
    assign mul_a_sel   = a_sel_q;
    assign mul_b_sel   = b_sel_q;
    assign mul_out_sel = o_sel_q;

endmodule

// File: tb/tb_matmul_job_sched.sv
// Bench for matmul_job_sched: directed scenarios with literal expectations, then
// random MMIO/done traffic checked every cycle against a queue-based job model.
module tb_matmul_job_sched;

    localparam int unsigned QD = 4;

    logic        clk;
    logic        rst;
    logic        mmio_w_req;
    logic [31:0] mmio_w_addr;
    logic [31:0] mmio_w_data;
    logic        mmio_r_req;
    logic [31:0] mmio_r_addr;
    logic [31:0] mmio_r_data;
    logic        mul_start;
    logic [3:0]  mul_a_sel, mul_b_sel, mul_out_sel;
    logic        mul_done;

    matmul_job_sched #(
        .MMIO_WIDTH(32), .MMIO_ADDRBITS(32), .QDEPTH(QD), .SEL_BITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .mmio_w_req(mmio_w_req), .mmio_w_addr(mmio_w_addr), .mmio_w_data(mmio_w_data),
        .mmio_r_req(mmio_r_req), .mmio_r_addr(mmio_r_addr), .mmio_r_data(mmio_r_data),
        .mul_start(mul_start), .mul_a_sel(mul_a_sel), .mul_b_sel(mul_b_sel),
        .mul_out_sel(mul_out_sel), .mul_done(mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: staged job, pending-job queue, and the datapath phase
    logic [3:0]  m_ja, m_jb, m_jo, m_a, m_b, m_o;
    logic [11:0] jobq[$];
    logic        m_ovf, m_start;
    logic [31:0] m_done, m_rdata;
    int          m_phase;   // 0 idle, 1 start cycle, 2 waiting for done

    int          n_start;
    logic [3:0]  started_a[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int occ;
        logic [3:0] nja, njb, njo;
        logic push, ovf_set, ovf_clr, dclr, dinc;
        if (rst) begin
            m_ja = 0; m_jb = 0; m_jo = 0; m_a = 0; m_b = 0; m_o = 0;
            jobq.delete(); m_ovf = 0; m_start = 0; m_done = 0; m_rdata = 0; m_phase = 0;
            return;
        end
        occ = jobq.size();
        if (mmio_r_req) begin
            case (mmio_r_addr)
                32'h00: m_rdata = 32'(m_ja);
                32'h08: m_rdata = 32'(m_jb);
                32'h10: m_rdata = 32'(m_jo);
                32'h20: m_rdata = {16'd0, 8'(occ), 6'd0, m_ovf, 1'(m_phase != 0)};
                32'h28: m_rdata = m_done;
                default: ;
            endcase
        end
        nja = m_ja; njb = m_jb; njo = m_jo;
        push = 0; ovf_set = 0; ovf_clr = 0; dclr = 0; dinc = 0;
        if (mmio_w_req) begin
            case (mmio_w_addr)
                32'h00: nja = mmio_w_data[3:0];
                32'h08: njb = mmio_w_data[3:0];
                32'h10: njo = mmio_w_data[3:0];
                32'h18: if (occ == QD) ovf_set = 1; else push = 1;
                32'h20: ovf_clr = mmio_w_data[1];
                32'h28: dclr = 1;
                default: ;
            endcase
        end
        m_start = 0;
        case (m_phase)
            0: if (occ > 0) begin
                {m_a, m_b, m_o} = jobq.pop_front();
                m_start = 1;
                m_phase = 1;
            end
            1: m_phase = 2;
            default: if (mul_done) begin dinc = 1; m_phase = 0; end
        endcase
        if (push) jobq.push_back({m_ja, m_jb, m_jo});
        m_ja = nja; m_jb = njb; m_jo = njo;
        if (ovf_set) m_ovf = 1; else if (ovf_clr) m_ovf = 0;
        if (dclr) m_done = 0; else if (dinc) m_done = m_done + 1;
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("mul_start",   32'(mul_start),   32'(m_start));
        check("mul_a_sel",   32'(mul_a_sel),   32'(m_a));
        check("mul_b_sel",   32'(mul_b_sel),   32'(m_b));
        check("mul_out_sel", 32'(mul_out_sel), 32'(m_o));
        check("mmio_r_data", mmio_r_data,      m_rdata);
        if (mul_start === 1'b1) begin
            n_start++;
            started_a.push_back(mul_a_sel);
        end
    endtask

    task automatic quiet();
        rst = 0; mmio_w_req = 0; mmio_r_req = 0; mul_done = 0;
        mmio_w_addr = 0; mmio_w_data = 0; mmio_r_addr = 0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        quiet();
        mmio_w_req = 1; mmio_w_addr = addr; mmio_w_data = data;
        cycle();
        quiet();
    endtask

    task automatic rd(input logic [31:0] addr);
        quiet();
        mmio_r_req = 1; mmio_r_addr = addr;
        cycle();
        quiet();
    endtask

    task automatic pulse_done();
        quiet();
        mul_done = 1;
        cycle();
        quiet();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] tbl [10] = '{32'h00, 32'h08, 32'h10, 32'h18, 32'h18,
                                  32'h18, 32'h20, 32'h28, 32'h04, 32'h30};
        return tbl[$urandom_range(0, 9)];
    endfunction

    logic [31:0] rv;

    initial begin
        quiet();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        check("reset_rdata", mmio_r_data, 32'h0);
        check("reset_start", 32'(mul_start), 32'h0);
        check("reset_sels", 32'({mul_a_sel, mul_b_sel, mul_out_sel}), 32'h0);

        // Single job, done five cycles after the start pulse
        wr(32'h00, 1); wr(32'h08, 2); wr(32'h10, 3);
        n_start = 0; started_a.delete();
        wr(32'h18, 32'hdead_beef);
        idle(1);
        check("t1_start_after_pop", 32'(n_start), 1);
        check("t1_sels", 32'({mul_a_sel, mul_b_sel, mul_out_sel}), 32'h123);
        idle(4);
        pulse_done();
        idle(2);
        rd(32'h28);
        check("t1_done_cnt", mmio_r_data, 1);
        check("t1_model_done", m_done, 1);
        rd(32'h20);
        rv = mmio_r_data;
        check("t1_busy", 32'(rv[0]), 0);
        check("t1_one_start", 32'(n_start), 1);

        // Four jobs in order
        wr(32'h28, 0);
        n_start = 0; started_a.delete();
        for (int i = 0; i < 4; i++) begin
            wr(32'h00, i); wr(32'h08, i); wr(32'h10, i); wr(32'h18, 0);
        end
        rd(32'h20);
        rv = mmio_r_data;
        check("t2_occupancy", 32'(rv[15:8]), 3);
        repeat (4) begin
            pulse_done();
            idle(3);
        end
        check("t2_starts", 32'(n_start), 4);
        for (int i = 0; i < 4; i++)
            if (i < started_a.size()) check("t2_order", 32'(started_a[i]), 32'(i));
        rd(32'h28);
        check("t2_done_cnt", mmio_r_data, 4);

        // Done ignored in IDLE and in the start cycle
        wr(32'h28, 0);
        pulse_done();
        wr(32'h18, 0);
        quiet(); mul_done = 1;
        cycle();
        cycle();
        quiet();
        rd(32'h28);
        check("t4_done_ignored", mmio_r_data, 0);
        rd(32'h20);
        rv = mmio_r_data;
        check("t4_busy_wait", 32'(rv[0]), 1);

        // Overflow while stalled in WAIT, then clear
        repeat (6) wr(32'h18, 0);
        rd(32'h20);
        rv = mmio_r_data;
        check("t3_occupancy", 32'(rv[15:8]), 4);
        check("t3_overflow", 32'(rv[1]), 1);
        wr(32'h20, 32'h2);
        rd(32'h20);
        rv = mmio_r_data;
        check("t3_overflow_clr", 32'(rv[1]), 0);

        // Doorbell on the pop edge with the FIFO full
        pulse_done();
        wr(32'h18, 0);
        rd(32'h20);
        rv = mmio_r_data;
        check("t6_occupancy", 32'(rv[15:8]), 3);
        check("t6_overflow", 32'(rv[1]), 1);

        // Reset mid-job with two queued
        idle(2);
        pulse_done();
        idle(3);
        rd(32'h20);
        rv = mmio_r_data;
        check("t5_occ_before", 32'(rv[15:8]), 2);
        quiet(); rst = 1;
        cycle();
        quiet();
        n_start = 0;
        pulse_done();
        idle(5);
        rd(32'h20);
        check("t5_status", mmio_r_data, 0);
        rd(32'h28);
        check("t5_done_cnt", mmio_r_data, 0);
        check("t5_no_start", 32'(n_start), 0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            mmio_w_req  = ($urandom_range(0, 2) == 0);
            mmio_w_addr = pick_addr();
            mmio_w_data = $urandom();
            mmio_r_req  = ($urandom_range(0, 1) == 0);
            mmio_r_addr = pick_addr();
            mul_done    = ($urandom_range(0, 4) == 0);
            cycle();
        end
        quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
